// File: rtl/dvp_capture_pkg.sv
// Shared definitions for the DVP capture path: FSM encoding, coordinate
// width and the RGB565 pixel layout consumed by the HDMI output path.
package dvp_capture_pkg;

    localparam int COORD_W = 12;
    localparam int BYTE_W  = 8;

    // RGB565 layout {r, g, b}, shared with the output path.
    localparam int RGB_R_W = 5;
    localparam int RGB_G_W = 6;
    localparam int RGB_B_W = 5;
    localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        CAPT = 2'd2
    } cap_state_t;

endpackage

// File: rtl/dvp_byte_packer.sv
// Front end of the DVP receiver: registers the camera bus once, detects
// frame start and line end, and pairs bytes (high first) into pixels.
module dvp_byte_packer
    import dvp_capture_pkg::*;
#(
    parameter logic VS_POL = 1'b1
) (
    input  logic              video_clk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [BYTE_W-1:0] cam_data,
    output logic              fs,
    output logic              href_fall,
    output logic              odd_drop,
    output logic              pix_vld_p1,
    output logic [PIX_W-1:0]  pix_data_p1
);

    logic              vs_r;
    logic              vs_d;
    logic              href_r;
    logic              href_d;
    logic [BYTE_W-1:0] data_r;
    logic [BYTE_W-1:0] hi_byte;
    logic              phase;

    // Sample the camera bus once; keep one more copy of the syncs for edges.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            href_r <= 1'b0;
            href_d <= 1'b0;
            data_r <= '0;
        end else begin
            vs_r   <= cam_vsync;
            vs_d   <= vs_r;
            href_r <= cam_href;
            href_d <= href_r;
            data_r <= cam_data;
        end
    end

    assign fs        = (vs_r == VS_POL) && (vs_d != VS_POL);
    assign href_fall = href_d && !href_r;
    // Line ended right after a high byte: that byte has no partner.
    assign odd_drop  = href_fall && phase;

    // Byte phase toggles through a line; frame start resynchronises it.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_byte <= '0;
        end else begin
            if (fs || !href_r) begin
                phase <= 1'b0;
            end else begin
                phase <= ~phase;
            end
            if (href_r && !phase) begin
                hi_byte <= data_r;
            end
        end
    end

    assign pix_vld_p1  = href_r && phase && !fs;
    assign pix_data_p1 = {hi_byte, data_r};

endmodule

// File: rtl/dvp_capture.sv
// DVP camera capture: frame-skip/capture FSM, x/y counters and the
// registered RGB565 pixel stream. Optional line/frame size measurement is
// built when DVP_TIMING_MEAS_EN is defined; otherwise its outputs are 0.
module dvp_capture
    import dvp_capture_pkg::*;
#(
    parameter logic [COORD_W-1:0] H_ACTIVE   = 12'd1280,
    parameter logic [COORD_W-1:0] V_ACTIVE   = 12'd720,
    parameter logic               VS_POL     = 1'b1,
    parameter logic [3:0]         FRAME_SKIP = 4'd3
) (
    input  logic               video_clk,
    input  logic               rst_n,
    input  logic               capture_en,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic [BYTE_W-1:0]  cam_data,
    output logic [PIX_W-1:0]   video_data,
    output logic               video_de,
    output logic               video_vs,
    output logic               frame_done,
    output logic [COORD_W-1:0] active_x,
    output logic [COORD_W-1:0] active_y,
    output logic [COORD_W-1:0] meas_width,
    output logic [COORD_W-1:0] meas_height,
    output logic               size_err
);

    logic               fs;
    logic               href_fall;
    logic               odd_drop;
    logic               pix_vld_p1;
    logic [PIX_W-1:0]   pix_data_p1;

    cap_state_t         state;
    cap_state_t         state_nxt;
    logic [3:0]         skip_cnt;
    logic [3:0]         skip_nxt;
    logic               vs_set;
    logic               done_set;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic               pix_keep;

    dvp_byte_packer #(
        .VS_POL (VS_POL)
    ) u_packer (
        .video_clk   (video_clk),
        .rst_n       (rst_n),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .fs          (fs),
        .href_fall   (href_fall),
        .odd_drop    (odd_drop),
        .pix_vld_p1  (pix_vld_p1),
        .pix_data_p1 (pix_data_p1)
    );

    // FSM state and settle-frame counter.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // Transitions only happen at frame start; capture_en is looked at there.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        vs_set    = 1'b0;
        done_set  = 1'b0;
        if (fs) begin
            case (state)
                IDLE: begin
                    if (capture_en) begin
                        skip_nxt = '0;
                        if (FRAME_SKIP == 4'd0) begin
                            state_nxt = CAPT;
                            vs_set    = 1'b1;
                        end else begin
                            state_nxt = SKIP;
                        end
                    end
                end
                SKIP: begin
                    if (!capture_en) begin
                        state_nxt = IDLE;
                    end else begin
                        skip_nxt = skip_cnt + 4'd1;
                        if (skip_cnt + 4'd1 == FRAME_SKIP) begin
                            state_nxt = CAPT;
                            vs_set    = 1'b1;
                        end
                    end
                end
                CAPT: begin
                    done_set = 1'b1;
                    if (capture_en) begin
                        vs_set = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Position counters; frame start overrides everything, x saturates.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (fs) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (href_fall) begin
            x_cnt <= '0;
            if ((x_cnt != '0) && (y_cnt != COORD_MAX)) begin
                y_cnt <= y_cnt + 12'd1;
            end
        end else if (pix_vld_p1 && (x_cnt != COORD_MAX)) begin
            x_cnt <= x_cnt + 12'd1;
        end
    end

    assign pix_keep = pix_vld_p1 && (state == CAPT) &&
                      (x_cnt < H_ACTIVE) && (y_cnt < V_ACTIVE);

    // Output stage: pixel and coordinates hold between strobes.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            video_data <= '0;
            video_de   <= 1'b0;
            video_vs   <= 1'b0;
            frame_done <= 1'b0;
            active_x   <= '0;
            active_y   <= '0;
        end else begin
            video_de   <= pix_keep;
            video_vs   <= vs_set;
            frame_done <= done_set;
            if (pix_keep) begin
                video_data <= pix_data_p1;
                active_x   <= x_cnt;
                active_y   <= y_cnt;
            end
        end
    end

`ifdef DVP_TIMING_MEAS_EN
    logic [COORD_W-1:0] meas_w_q;
    logic [COORD_W-1:0] meas_h_q;
    logic               err_q;

    // Latch measured sizes while capturing; error is sticky until disable.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_w_q <= '0;
            meas_h_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state == CAPT) && href_fall && !fs) begin
                meas_w_q <= x_cnt;
            end
            if ((state == CAPT) && fs) begin
                meas_h_q <= y_cnt;
            end
            if (!capture_en) begin
                err_q <= 1'b0;
            end else if ((state == CAPT) &&
                         ((href_fall && !fs && ((x_cnt != H_ACTIVE) || odd_drop)) ||
                          (fs && (y_cnt != V_ACTIVE)))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign meas_width  = meas_w_q;
    assign meas_height = meas_h_q;
    assign size_err    = err_q;
`else
    logic meas_unused;
    assign meas_unused = odd_drop;
    assign meas_width  = '0;
    assign meas_height = '0;
    assign size_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_capture.sv
// Bench for dvp_capture with H_ACTIVE=4, V_ACTIVE=2, FRAME_SKIP=2.
// Drivers push expected pixels into a queue; a negedge monitor pops and
// compares every video_de, including the cycle it arrives on.
`timescale 1ns/1ps
module tb_dvp_capture;

    localparam int H = 4;
    localparam int V = 2;

    logic        video_clk  = 1'b0;
    logic        rst_n      = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_vsync  = 1'b0;
    logic        cam_href   = 1'b0;
    logic [7:0]  cam_data   = 8'h00;
    logic [15:0] video_data;
    logic        video_de;
    logic        video_vs;
    logic        frame_done;
    logic [11:0] active_x;
    logic [11:0] active_y;
    logic [11:0] meas_width;
    logic [11:0] meas_height;
    logic        size_err;

    dvp_capture #(
        .H_ACTIVE   (12'd4),
        .V_ACTIVE   (12'd2),
        .VS_POL     (1'b1),
        .FRAME_SKIP (4'd2)
    ) dut (
        .video_clk   (video_clk),
        .rst_n       (rst_n),
        .capture_en  (capture_en),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .video_data  (video_data),
        .video_de    (video_de),
        .video_vs    (video_vs),
        .frame_done  (frame_done),
        .active_x    (active_x),
        .active_y    (active_y),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .size_err    (size_err)
    );

    always #5 video_clk = ~video_clk;

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        int          c;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc         = 0;
    int         vectors     = 0;
    int         miscompares = 0;
    int         vs_cnt      = 0;
    int         fd_cnt      = 0;
    int         pix_cnt     = 0;
    logic [7:0] line_buf[0:15];

    always @(posedge video_clk) cyc <= cyc + 1;

    // Monitor: every pixel strobe must match the head of the scoreboard.
    always @(negedge video_clk) begin
        if (rst_n) begin
            if (video_vs)   vs_cnt++;
            if (frame_done) fd_cnt++;
            if (video_de) begin
                pix_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stray_de: got data=%h x=%0d y=%0d cyc=%0d, required no pixel",
                             video_data, active_x, active_y, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (video_data !== mon_e.d || active_x !== 12'(mon_e.x) ||
                        active_y !== 12'(mon_e.y) || cyc != mon_e.c) begin
                        miscompares++;
                        $display("FAIL pixel: got data=%h x=%0d y=%0d cyc=%0d, required data=%h x=%0d y=%0d cyc=%0d",
                                 video_data, active_x, active_y, cyc,
                                 mon_e.d, mon_e.x, mon_e.y, mon_e.c);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(video_data),  32'd0);
        check({tag, "_de"},    32'(video_de),    32'd0);
        check({tag, "_vs"},    32'(video_vs),    32'd0);
        check({tag, "_done"},  32'(frame_done),  32'd0);
        check({tag, "_x"},     32'(active_x),    32'd0);
        check({tag, "_y"},     32'(active_y),    32'd0);
        check({tag, "_mw"},    32'(meas_width),  32'd0);
        check({tag, "_mh"},    32'(meas_height), 32'd0);
        check({tag, "_err"},   32'(size_err),    32'd0);
    endtask

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic frame_start();
        tick(); cam_vsync = 1'b1;
        tick();
        tick(); cam_vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic fill(input int n, input logic [7:0] start);
        for (int i = 0; i < n; i++) line_buf[i] = start + 8'(i);
    endtask

    // Drive one line; when capt is set, kept pixels are expected 2 cycles
    // after their low byte is on the bus.
    task automatic drive_line(input int n, input int y, input bit capt);
        exp_t e;
        int   x;
        x = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            cam_href = 1'b1;
            cam_data = line_buf[i];
            if (i % 2 == 1) begin
                if (capt && x < H && y < V) begin
                    e.d = {line_buf[i-1], line_buf[i]};
                    e.x = x;
                    e.y = y;
                    e.c = cyc + 2;
                    exp_q.push_back(e);
                end
                x++;
            end
        end
        tick(); cam_href = 1'b0; cam_data = 8'h00;
        repeat (3) tick();
    endtask

    initial begin
        exp_t e;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        capture_en = 1'b1;

        // Two settling frames: nothing may come out.
        for (int f = 0; f < 2; f++) begin
            frame_start();
            fill(8, 8'h40); drive_line(8, 0, 1'b0);
            fill(8, 8'h48); drive_line(8, 1, 1'b0);
        end

        // First captured frame, byte packing and latency.
        frame_start();
        line_buf[0] = 8'hA5; line_buf[1] = 8'h3C; line_buf[2] = 8'h0F; line_buf[3] = 8'hF0;
        line_buf[4] = 8'h11; line_buf[5] = 8'h22; line_buf[6] = 8'h33; line_buf[7] = 8'h44;
        drive_line(8, 0, 1'b1);
        fill(8, 8'h01); drive_line(8, 1, 1'b1);
        check("vs_f3",  32'(vs_cnt),  32'd1);
        check("fd_f3",  32'(fd_cnt),  32'd0);
        check("pix_f3", 32'(pix_cnt), 32'd8);

        // Odd byte count, horizontal clip, vertical clip.
        frame_start();
        check("vs_f4", 32'(vs_cnt), 32'd2);
        check("fd_f4", 32'(fd_cnt), 32'd1);
`ifdef DVP_TIMING_MEAS_EN
        check("meas_h_f3",   32'(meas_height), 32'd2);
        check("err_f3_ok",   32'(size_err),    32'd0);
`endif
        line_buf[0] = 8'hDE; line_buf[1] = 8'hAD; line_buf[2] = 8'hBE; line_buf[3] = 8'hEF;
        line_buf[4] = 8'hCA; line_buf[5] = 8'hFE; line_buf[6] = 8'h77;
        drive_line(7, 0, 1'b1);
`ifdef DVP_TIMING_MEAS_EN
        check("meas_w_odd", 32'(meas_width), 32'd3);
        check("err_odd",    32'(size_err),   32'd1);
`else
        check("meas_w_off", 32'(meas_width), 32'd0);
        check("err_off",    32'(size_err),   32'd0);
`endif
        fill(12, 8'h10); drive_line(12, 1, 1'b1);
`ifdef DVP_TIMING_MEAS_EN
        check("meas_w_long", 32'(meas_width), 32'd6);
`endif
        fill(8, 8'h60); drive_line(8, 2, 1'b1);
        check("pix_f4", 32'(pix_cnt), 32'd15);

        // Reset in the middle of a captured line.
        frame_start();
        tick(); cam_href = 1'b1; cam_data = 8'h5A;
        tick(); cam_data = 8'hC3;
        e.d = 16'h5AC3; e.x = 0; e.y = 0; e.c = cyc + 2;
        exp_q.push_back(e);
        tick(); cam_data = 8'h99;
        tick();
        @(negedge video_clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midline_rst");
        tick(); cam_data = 8'h42;
        tick(); cam_href = 1'b0; cam_data = 8'h00;
        tick(); rst_n = 1'b1;
        check("vs_f5",  32'(vs_cnt),  32'd3);
        check("fd_f5",  32'(fd_cnt),  32'd2);
        check("pix_f5", 32'(pix_cnt), 32'd16);

        // Settle again after reset, then capture and disable mid-frame.
        for (int f = 0; f < 2; f++) begin
            frame_start();
            fill(8, 8'h70); drive_line(8, 0, 1'b0);
        end
        frame_start();
        fill(8, 8'h21); drive_line(8, 0, 1'b1);
        capture_en = 1'b0;
        fill(8, 8'h31); drive_line(8, 1, 1'b1);
        frame_start();
        check("fd_disable",  32'(fd_cnt),   32'd3);
        check("err_cleared", 32'(size_err), 32'd0);
        fill(8, 8'h81); drive_line(8, 0, 1'b0);
        frame_start();
        fill(8, 8'h91); drive_line(8, 0, 1'b0);
        check("vs_end",    32'(vs_cnt),        32'd4);
        check("fd_end",    32'(fd_cnt),        32'd3);
        check("pix_end",   32'(pix_cnt),       32'd24);
        check("queue_end", 32'(exp_q.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dvp_capture.md
Name: dvp_capture

Overview:
- DVP camera input receiver: samples 8-bit parallel camera bus (vsync/href/data) on the pixel clock and packs byte pairs into RGB565 pixels.
- Regenerates a clean pixel stream: data, de, frame-start, x/y position.
- Sits at the front of the DVP video path, upstream of the frame buffer writer.
- Its 16-bit RGB565 {r[4:0],g[5:0],b[4:0]} pixel format is the one the HDMI output path consumes.

Parameters:
- H_ACTIVE, 12'd1280: pixels per line kept; later pixels in a line are dropped.
- V_ACTIVE, 12'd720: lines per frame kept; later lines are dropped.
- VS_POL, 1'b1: cam_vsync active level; 1 = active high.
- FRAME_SKIP, 4'd3: complete frames discarded after enable, for sensor settling.

Ports:
- video_clk, in, 1: pixel clock (camera PCLK domain).
- rst_n, in, 1: asynchronous active-low reset.
- capture_en, in, 1: capture enable; sampled at frame start only.
- cam_vsync, in, 1: camera vertical sync.
- cam_href, in, 1: camera line valid.
- cam_data, in, 8: camera byte, high byte of each pixel first.
- video_data, out, 16: RGB565 pixel.
- video_de, out, 1: one-cycle pixel-valid strobe.
- video_vs, out, 1: one-cycle frame-start pulse (first captured frame onward).
- frame_done, out, 1: one-cycle pulse at the end of each captured frame.
- active_x, out, 12: x of the current video_data.
- active_y, out, 12: y of the current video_data.
- meas_width, out, 12: measured pixels in the last line (feature only).
- meas_height, out, 12: measured lines in the last frame (feature only).
- size_err, out, 1: sticky size mismatch flag (feature only).

Behaviour:
- Reset: all outputs, counters and input registers are 0; state IDLE. Reset mid-frame aborts immediately; no partial pixel is emitted.
- Input stage: cam_vsync, cam_href and cam_data are registered once. All logic uses these registered copies (vs_r, href_r, data_r).
- Frame start (fs) = vs_r changes to the VS_POL level (edge detect against the previous vs_r).
- FSM:
  - IDLE: on fs with capture_en=1, go to SKIP with skip_cnt=0. If FRAME_SKIP=0, go straight to CAPT.
  - SKIP: each fs increments skip_cnt. When skip_cnt reaches FRAME_SKIP, go to CAPT at that fs. No output activity in SKIP.
  - CAPT: on each fs, pulse frame_done (except on the fs that entered CAPT), then:
    - if capture_en=1, pulse video_vs;
    - if capture_en=0, return to IDLE.
- Byte phase: phase is cleared while href_r=0 and toggles on each cycle with href_r=1.
  - phase 0: latch data_r as the high byte.
  - phase 1: form the pixel {hi, data_r}.
- Pixel output (CAPT only): when a pixel forms and x<H_ACTIVE and y<V_ACTIVE:
  - video_data is registered;
  - video_de=1 for 1 cycle;
  - active_x/active_y carry the pixel's coordinates.
- Latency: video_de asserts 2 cycles after the low byte is on cam_data.
- video_data holds its last value while video_de=0.
- x counter: increments per formed pixel and saturates at 4095. It clears on href_r falling edge.
- y counter: increments on href_r falling edge if x>0. Cleared on fs.
- Odd byte count when href falls: the dangling high byte is dropped and no pixel is emitted.
- fs while href_r=1 (malformed input): fs wins; counters and phase clear.
- Simultaneous href fall and fs: fs takes priority; y=0.

Optional Feature:
- Macro: DVP_TIMING_MEAS_EN.
- With the macro defined:
  - meas_width latches the final x on each href fall.
  - meas_height latches y on each fs in CAPT.
  - size_err sets if a latched value ≠ H_ACTIVE / V_ACTIVE respectively, or on an odd byte count.
  - size_err clears only on reset or capture_en=0.
- Without the macro: meas_width, meas_height and size_err are tied to 0 and no measurement logic is generated.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE=2'd0, SKIP=2'd1, CAPT=2'd2.
  - 12-bit coordinate width constant.
  - RGB565 field-width constants, shared with the output path.
- One natural sub-module: dvp_byte_packer (input register, phase toggle, high-byte latch, pixel-valid output).
- FSM, counters and the feature live in the top.

Test Plan:
- Frame skip: H_ACTIVE=4, V_ACTIVE=2, FRAME_SKIP=2, three frames of 2 lines × 8 bytes -> no video_de in frames 1–2; frame 3 gives 8 video_de pulses and video_vs exactly once.
- Byte packing: bytes A5,3C,0F,F0 -> video_data=16'hA53C then 16'h0FF0; active_x=0,1; video_de 2 cycles after bytes 3C and F0.
- Clipping: line of 12 bytes (6 pixels), H_ACTIVE=4 -> 4 pulses, x 0..3. A third line with V_ACTIVE=2 -> no pulses.
- Odd bytes: line of 7 bytes -> 3 pixels; with DVP_TIMING_MEAS_EN, meas_width=3 and size_err=1.
- Disable: capture_en dropped mid-frame -> current frame completes, frame_done pulses at next fs, then IDLE with no video_vs.
- Reset mid-line: rst_n low during a line -> all outputs 0 and no stray video_de after release until FRAME_SKIP frames pass.
